// File: rtl/hazard_pkg.sv
// Shared widths, stage-field struct and instruction slice positions for the
// hazard stage tracker.
package hazard_pkg;

    localparam int REG_W      = 5;
    localparam int OP_W       = 6;
    localparam int NUM_STAGES = 3;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;

    typedef struct packed {
        logic [REG_W-1:0] reg_dst;
        logic             mem_read;
        logic             reg_write;
    } stage_fields_t;

    localparam stage_fields_t BUBBLE = '0;

    // Only the instruction fields the detector looks at are kept in IF/ID.
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
    } ifid_t;

    typedef enum logic [1:0] {
        STAGE_LOAD,
        STAGE_HOLD,
        STAGE_BUBBLE
    } stage_op_t;

    // The most-downstream stalled stage bubbles; stalled stages above it hold.
    function automatic stage_op_t stage_op(input logic stall, input logic stall_dn);
        if (!stall)
            return STAGE_LOAD;
        else if (stall_dn)
            return STAGE_HOLD;
        else
            return STAGE_BUBBLE;
    endfunction

endpackage

// File: rtl/hazard_stage_tracker_if.sv
// Hazard-unit <-> stage-tracker bundle: commands and decode inputs in,
// per-stage feedback, stall statistics and retire count out.
interface hazard_stage_tracker_if #(parameter int CNT_W = 16);
    import hazard_pkg::*;

    logic [31:0]      Instr_IF;
    logic [REG_W-1:0] RegDst_DEC;
    logic             MemRead_DEC;
    logic             RegWrite_DEC;
    logic             IFID_Write;
    logic             IF_Flush;
    logic             stall_IDEX;
    logic             stall_EXMEM;
    logic             stall_MEMWB;

    logic [REG_W-1:0] Rs_DEC;
    logic [REG_W-1:0] Rt_DEC;
    logic [OP_W-1:0]  Op;
    logic [REG_W-1:0] RegDst_EX;
    logic [REG_W-1:0] RegDst_MEM;
    logic [REG_W-1:0] RegDst_WB;
    logic             MemRead_EX;
    logic             MemRead_MEM;
    logic             MemRead_WB;
    logic             RegWrite_EX;
    logic             RegWrite_MEM;
    logic             RegWrite_WB;
    logic [CNT_W-1:0] StallCycles;
    logic             Deadlock;
    logic [31:0]      Retired;

    modport master (
        output Instr_IF, RegDst_DEC, MemRead_DEC, RegWrite_DEC,
               IFID_Write, IF_Flush, stall_IDEX, stall_EXMEM, stall_MEMWB,
        input  Rs_DEC, Rt_DEC, Op, RegDst_EX, RegDst_MEM, RegDst_WB,
               MemRead_EX, MemRead_MEM, MemRead_WB,
               RegWrite_EX, RegWrite_MEM, RegWrite_WB,
               StallCycles, Deadlock, Retired
    );

    modport slave (
        input  Instr_IF, RegDst_DEC, MemRead_DEC, RegWrite_DEC,
               IFID_Write, IF_Flush, stall_IDEX, stall_EXMEM, stall_MEMWB,
        output Rs_DEC, Rt_DEC, Op, RegDst_EX, RegDst_MEM, RegDst_WB,
               MemRead_EX, MemRead_MEM, MemRead_WB,
               RegWrite_EX, RegWrite_MEM, RegWrite_WB,
               StallCycles, Deadlock, Retired
    );

endinterface

// File: rtl/hazard_stage_reg.sv
// One pipeline stage register of hazard-relevant fields; bubble beats hold.
// With HAZ_TRACK_VALID_EN it also carries a valid bit.
module hazard_stage_reg
    import hazard_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  stage_fields_t d,
    input  logic          bubble,
    input  logic          hold,
`ifdef HAZ_TRACK_VALID_EN
    input  logic          d_valid,
    output logic          q_valid,
`endif
    output stage_fields_t q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= BUBBLE;
        else if (bubble)
            q <= BUBBLE;
        else if (!hold)
            q <= d;
    end

`ifdef HAZ_TRACK_VALID_EN
    always_ff @(posedge clk) begin
        if (rst)
            q_valid <= 1'b0;
        else if (bubble)
            q_valid <= 1'b0;
        else if (!hold)
            q_valid <= d_valid;
    end
`endif

endmodule

// File: rtl/hazard_stage_tracker.sv
// Applies hazard-unit hold/bubble/flush to IF/ID..MEM/WB, feeds stage fields
// back, counts bubble cycles and flags a deadlock. Option: HAZ_TRACK_VALID_EN.
module hazard_stage_tracker
    import hazard_pkg::*;
#(
    parameter int STALL_LIMIT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    hazard_stage_tracker_if.slave  bus
);

    localparam int RUN_W = $clog2(STALL_LIMIT + 1);

    ifid_t                           ifid_q;
    stage_fields_t                   dec;
    stage_fields_t [NUM_STAGES-1:0]  d;
    stage_fields_t [NUM_STAGES-1:0]  q;
    logic [NUM_STAGES-1:0]           stall;
    logic [NUM_STAGES-1:0]           stall_dn;
    logic [NUM_STAGES-1:0]           bubble;
    logic [NUM_STAGES-1:0]           hold;
    logic                            any_bubble;
    logic [CNT_W-1:0]                stall_cycles;
    logic [RUN_W-1:0]                run_cnt;
    logic                            deadlock;

    // Index 0 = ID/EX, 2 = MEM/WB; MEM/WB has nothing below it.
    assign stall    = {bus.stall_MEMWB, bus.stall_EXMEM, bus.stall_IDEX};
    assign stall_dn = {1'b0, stall[NUM_STAGES-1:1]};
    assign dec      = {bus.RegDst_DEC, bus.MemRead_DEC, bus.RegWrite_DEC};
    assign d        = {q[1], q[0], dec};
    assign any_bubble = |bubble;

`ifdef HAZ_TRACK_VALID_EN
    logic                  ifid_valid;
    logic [NUM_STAGES-1:0] dv;
    logic [NUM_STAGES-1:0] qv;
    logic [31:0]           retired;

    assign dv = {qv[1], qv[0], ifid_valid};
`endif

    always_ff @(posedge Clk) begin
        if (Reset)
            ifid_q <= '0;
        else if (bus.IF_Flush)
            ifid_q <= '0;
        else if (bus.IFID_Write)
            ifid_q <= '{op: bus.Instr_IF[OP_HI:OP_LO],
                        rs: bus.Instr_IF[RS_HI:RS_LO],
                        rt: bus.Instr_IF[RT_HI:RT_LO]};
    end

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        stage_op_t sop;
        assign sop       = stage_op(stall[i], stall_dn[i]);
        assign bubble[i] = (sop == STAGE_BUBBLE);
        assign hold[i]   = (sop == STAGE_HOLD);

        hazard_stage_reg u_reg (
            .clk     (Clk),
            .rst     (Reset),
            .d       (d[i]),
            .bubble  (bubble[i]),
            .hold    (hold[i]),
`ifdef HAZ_TRACK_VALID_EN
            .d_valid (dv[i]),
            .q_valid (qv[i]),
`endif
            .q       (q[i])
        );
    end

    // Run counter saturates at the limit so deadlock can be judged on it alone.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cycles <= '0;
            run_cnt      <= '0;
            deadlock     <= 1'b0;
        end else begin
            if (any_bubble && stall_cycles != {CNT_W{1'b1}})
                stall_cycles <= stall_cycles + 1'b1;
            if (!any_bubble)
                run_cnt <= '0;
            else if (run_cnt != RUN_W'(STALL_LIMIT))
                run_cnt <= run_cnt + 1'b1;
            if (any_bubble && run_cnt >= RUN_W'(STALL_LIMIT - 1))
                deadlock <= 1'b1;
        end
    end

`ifdef HAZ_TRACK_VALID_EN
    always_ff @(posedge Clk) begin
        if (Reset)
            ifid_valid <= 1'b0;
        else if (bus.IF_Flush)
            ifid_valid <= 1'b0;
        else if (bus.IFID_Write)
            ifid_valid <= 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            retired <= '0;
        else if (qv[NUM_STAGES-1])
            retired <= retired + 32'd1;
    end

    assign bus.Retired = retired;
`else
    assign bus.Retired = '0;
`endif

    assign bus.Op           = ifid_q.op;
    assign bus.Rs_DEC       = ifid_q.rs;
    assign bus.Rt_DEC       = ifid_q.rt;
    assign bus.RegDst_EX    = q[0].reg_dst;
    assign bus.MemRead_EX   = q[0].mem_read;
    assign bus.RegWrite_EX  = q[0].reg_write;
    assign bus.RegDst_MEM   = q[1].reg_dst;
    assign bus.MemRead_MEM  = q[1].mem_read;
    assign bus.RegWrite_MEM = q[1].reg_write;
    assign bus.RegDst_WB    = q[2].reg_dst;
    assign bus.MemRead_WB   = q[2].mem_read;
    assign bus.RegWrite_WB  = q[2].reg_write;
    assign bus.StallCycles  = stall_cycles;
    assign bus.Deadlock     = deadlock;

endmodule

// File: tb/tb_hazard_stage_tracker.sv
// Table-driven check of hazard_stage_tracker (STALL_LIMIT=4, CNT_W=4) with a
// scoreboard queue of expected post-edge outputs.
module tb_hazard_stage_tracker;
    import hazard_pkg::*;

    localparam int LIMIT = 4;
    localparam int CW    = 4;

    typedef struct packed {
        logic          rst;
        logic [31:0]   instr;
        stage_fields_t dec;
        logic          wr;
        logic          fl;
        logic          s1;
        logic          s2;
        logic          s3;
    } in_t;

    typedef struct packed {
        logic [5:0]    op;
        logic [4:0]    rs;
        logic [4:0]    rt;
        stage_fields_t ex;
        stage_fields_t mem;
        stage_fields_t wb;
        logic [CW-1:0] sc;
        logic          dl;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    hazard_stage_tracker_if #(.CNT_W(CW)) bus ();

    hazard_stage_tracker #(.STALL_LIMIT(LIMIT), .CNT_W(CW)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic stage_fields_t st(input int dst, input int mr, input int rw);
        return {5'(dst), 1'(mr), 1'(rw)};
    endfunction

    function automatic void add(input int r, input logic [31:0] ins, input stage_fields_t dc,
                                input int wr, input int fl, input int s1, input int s2, input int s3,
                                input int op, input int rs, input int rt,
                                input stage_fields_t ex, input stage_fields_t mem, input stage_fields_t wb,
                                input int sc, input int dl);
        vec_t v;
        v.i = '{rst: 1'(r), instr: ins, dec: dc, wr: 1'(wr), fl: 1'(fl),
                s1: 1'(s1), s2: 1'(s2), s3: 1'(s3)};
        v.e = '{op: 6'(op), rs: 5'(rs), rt: 5'(rt), ex: ex, mem: mem, wb: wb,
                sc: CW'(sc), dl: 1'(dl)};
        tbl.push_back(v);
    endfunction

    task automatic apply(input int idx, input vec_t v);
        exp_t want;
        exp_t got;
        @(negedge clk);
        rst              = v.i.rst;
        bus.Instr_IF     = v.i.instr;
        bus.RegDst_DEC   = v.i.dec.reg_dst;
        bus.MemRead_DEC  = v.i.dec.mem_read;
        bus.RegWrite_DEC = v.i.dec.reg_write;
        bus.IFID_Write   = v.i.wr;
        bus.IF_Flush     = v.i.fl;
        bus.stall_IDEX   = v.i.s1;
        bus.stall_EXMEM  = v.i.s2;
        bus.stall_MEMWB  = v.i.s3;
        sb.push_back(v.e);
        @(posedge clk);
        #1;
        want = sb.pop_front();
        got  = '{op: bus.Op, rs: bus.Rs_DEC, rt: bus.Rt_DEC,
                 ex:  {bus.RegDst_EX,  bus.MemRead_EX,  bus.RegWrite_EX},
                 mem: {bus.RegDst_MEM, bus.MemRead_MEM, bus.RegWrite_MEM},
                 wb:  {bus.RegDst_WB,  bus.MemRead_WB,  bus.RegWrite_WB},
                 sc: bus.StallCycles, dl: bus.Deadlock};
        n_cmp++;
        if (got !== want || bus.Retired !== 32'd0) begin
            n_bad++;
            $display("FAIL step%0d: got op=%h rs=%0d rt=%0d ex=%h mem=%h wb=%h sc=%0d dl=%b ret=%0d, want op=%h rs=%0d rt=%0d ex=%h mem=%h wb=%h sc=%0d dl=%b ret=0",
                     idx, got.op, got.rs, got.rt, got.ex, got.mem, got.wb, got.sc, got.dl, bus.Retired,
                     want.op, want.rs, want.rt, want.ex, want.mem, want.wb, want.sc, want.dl);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        stage_fields_t z;
        a = 32'h8C2A0004;   // op 23, rs 1, rt 10
        b = 32'h00E83020;   // op 0, rs 7, rt 8
        c = 32'h014B6020;   // op 0, rs 10, rt 11
        z = BUBBLE;

        bus.Instr_IF = '0; bus.RegDst_DEC = '0; bus.MemRead_DEC = 1'b0; bus.RegWrite_DEC = 1'b0;
        bus.IFID_Write = 1'b1; bus.IF_Flush = 1'b0;
        bus.stall_IDEX = 1'b0; bus.stall_EXMEM = 1'b0; bus.stall_MEMWB = 1'b0;

        //   r  instr dec          wr fl s1 s2 s3  op    rs  rt  ex            mem           wb            sc  dl
        add(1, a, st(10,1,0),  1, 0, 0, 0, 0,  0,    0,  0,  z,            z,            z,            0,  0);
        add(0, a, st(10,1,1),  1, 0, 0, 0, 0,  'h23, 1,  10, st(10,1,1),   z,            z,            0,  0);
        add(0, b, st(7,0,1),   0, 0, 1, 0, 0,  'h23, 1,  10, z,            st(10,1,1),   z,            1,  0);
        add(0, b, st(5,0,1),   1, 0, 0, 0, 0,  0,    7,  8,  st(5,0,1),    z,            st(10,1,1),   1,  0);
        add(0, c, st(7,1,1),   1, 0, 0, 0, 0,  0,    10, 11, st(7,1,1),    st(5,0,1),    z,            1,  0);
        // ID/EX holds, EX/MEM bubbles, MEM/WB takes the old EX/MEM
        add(0, a, st(3,0,1),   0, 0, 1, 1, 0,  0,    10, 11, st(7,1,1),    z,            st(5,0,1),    2,  0);
        add(0, c, st(9,0,1),   1, 0, 0, 0, 0,  0,    10, 11, st(9,0,1),    st(7,1,1),    z,            2,  0);
        // all three stalled: only MEM/WB bubbles, then release loses nothing
        add(0, a, st(3,0,1),   0, 0, 1, 1, 1,  0,    10, 11, st(9,0,1),    st(7,1,1),    z,            3,  0);
        add(0, c, st(12,0,1),  1, 0, 0, 0, 0,  0,    10, 11, st(12,0,1),   st(9,0,1),    st(7,1,1),    3,  0);
        add(0, c, st(13,1,0),  1, 0, 0, 0, 0,  0,    10, 11, st(13,1,0),   st(12,0,1),   st(9,0,1),    3,  0);
        // flush beats hold and is not a bubble cycle
        add(0, a, st(14,0,1),  0, 1, 0, 0, 0,  0,    0,  0,  st(14,0,1),   st(13,1,0),   st(12,0,1),   3,  0);
        // three-bubble run stays below the limit
        add(0, a, st(2,1,1),   1, 0, 1, 0, 0,  'h23, 1,  10, z,            st(14,0,1),   st(13,1,0),   4,  0);
        add(0, a, st(2,1,1),   1, 0, 1, 0, 0,  'h23, 1,  10, z,            z,            st(14,0,1),   5,  0);
        add(0, a, st(2,1,1),   1, 0, 1, 0, 0,  'h23, 1,  10, z,            z,            z,            6,  0);
        add(0, a, st(6,1,1),   1, 0, 0, 0, 0,  'h23, 1,  10, st(6,1,1),    z,            z,            6,  0);
        // four-bubble run reaches the limit; deadlock is sticky
        add(0, a, st(2,1,1),   1, 0, 1, 0, 0,  'h23, 1,  10, z,            st(6,1,1),    z,            7,  0);
        add(0, a, st(2,1,1),   1, 0, 1, 0, 0,  'h23, 1,  10, z,            z,            st(6,1,1),    8,  0);
        add(0, a, st(2,1,1),   1, 0, 1, 0, 0,  'h23, 1,  10, z,            z,            z,            9,  0);
        add(0, a, st(2,1,1),   1, 0, 1, 0, 0,  'h23, 1,  10, z,            z,            z,            10, 1);
        add(0, a, st(6,1,1),   1, 0, 0, 0, 0,  'h23, 1,  10, st(6,1,1),    z,            z,            10, 1);
        // MEM/WB-only bubbles drive the counter into saturation at 15
        for (int k = 0; k < 6; k++)
            add(0, a, st(6,1,1), 1, 0, 0, 0, 1, 'h23, 1, 10, st(6,1,1), st(6,1,1), z,
                (11 + k > 15) ? 15 : 11 + k, 1);
        // reset clears everything, including the sticky flag
        add(1, a, st(10,1,1),  1, 0, 1, 1, 1,  0,    0,  0,  z,            z,            z,            0,  0);
        add(0, a, st(10,1,1),  1, 0, 0, 0, 0,  'h23, 1,  10, st(10,1,1),   z,            z,            0,  0);

        for (int k = 0; k < tbl.size(); k++)
            apply(k, tbl[k]);

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_stage_tracker.md
Name: hazard_stage_tracker

Overview:
- Sequential responder to the hazard detection unit's stall/flush commands.
- Holds the IF/ID, ID/EX, EX/MEM and MEM/WB hazard-relevant fields, applying hold, bubble and flush per cycle.
- Feeds the per-stage fields back to the detector: RegDst_*, MemRead_*, RegWrite_*, Rs_DEC, Rt_DEC and Op.
- Also counts stall cycles and flags a stall deadlock.

Parameters:
- STALL_LIMIT, 16, consecutive bubble cycles before Deadlock asserts.
- CNT_W, 16, width of the StallCycles counter.

Ports:
- Clk  in  1  pipeline clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Instr_IF  in  32  fetched instruction word.
- RegDst_DEC  in  5  destination register resolved by decode control.
- MemRead_DEC  in  1  decode-stage load flag.
- RegWrite_DEC  in  1  decode-stage register-write flag.
- IFID_Write, IF_Flush  in  1 each  from the hazard unit; 1 = perform the action.
- stall_IDEX, stall_EXMEM, stall_MEMWB  in  1 each  from the hazard unit; 1 = stall/bubble that register.
- Rs_DEC, Rt_DEC  out  5 each  IF/ID Instr[25:21] and Instr[20:16].
- Op  out  6  IF/ID Instr[31:26].
- RegDst_EX, RegDst_MEM, RegDst_WB  out  5 each  stage destination registers.
- MemRead_EX, MemRead_MEM, MemRead_WB  out  1 each  stage load flags.
- RegWrite_EX, RegWrite_MEM, RegWrite_WB  out  1 each  stage write flags.
- StallCycles  out  CNT_W  saturating count of cycles with any bubble inserted.
- Deadlock  out  1  sticky; set when the bubble run reaches STALL_LIMIT.

Behaviour:
- Reset (sync, high): every register, StallCycles and Deadlock go to 0. The outputs are then 0 the following cycle. Reset overrides all other inputs in the same cycle.
- All outputs come directly from flops, with no combinational path from stall/flush inputs to outputs. The hazard unit therefore sees the effect one cycle after it asserts a command.
- IF/ID register (Instr) priority:
  - IF_Flush=1 loads 32'h0.
  - else IFID_Write=0 holds.
  - else loads Instr_IF.
  - Flush beats hold.
- Pipeline registers, stage order ID/EX -> EX/MEM -> MEM/WB. Each stage X has the fields {RegDst, MemRead, RegWrite}.
  - stall_X=1 and the next-downstream stall=0: X loads a bubble (all fields 0).
  - stall_X=1 and the downstream stall=1: X holds.
  - stall_X=0: X loads the upstream stage, or the *_DEC inputs for ID/EX.
  - MEM/WB has no downstream stage, so stall_MEMWB=1 always bubbles MEM/WB.
  - Net effect: only the most-downstream asserted stage bubbles, and upstream asserted stages hold.
  - A stall_X=0 stage below a holding stage still advances. Example: EX/MEM holds and MEM/WB loads EX/MEM, so EX/MEM's content appears in both.
- Bubble definition: any stage register loads zeros this cycle.
- StallCycles: +1 on each bubble cycle; saturates at 2^CNT_W-1 and never wraps.
- Run counter: +1 on each bubble cycle, cleared on any non-bubble cycle. When it reaches STALL_LIMIT, Deadlock sets and stays set until Reset. The run counter saturates at STALL_LIMIT.
- Flush-only cycles (IF_Flush with no stage bubble) do not count.

Optional Feature:
- Macro: HAZ_TRACK_VALID_EN.
- When defined:
  - Each stage carries a valid bit. IF/ID valid = !IF_Flush at load.
  - Bubbles clear valid; holds keep it.
  - Output port Retired [31:0] counts valid MEM/WB entries, wraps modulo 2^32, and is 0 at reset.
- When undefined: no valid bits; Retired is driven constant 0.

Decomposition:
- Shared package hazard_pkg holds:
  - field widths (REG_W=5, OP_W=6);
  - the stage-fields struct {RegDst, MemRead, RegWrite} and its BUBBLE constant (all zero);
  - the instruction bit-slice positions.
- One sub-module, hazard_stage_reg, is natural: a single stage register with inputs d, bubble and hold, instantiated three times. Bubble has priority over hold inside it.

Test Plan:
- Reset with Instr_IF=32'h8C2A0004 asserted -> all outputs 0 next cycle. Release, then 1 cycle -> Op=6'h23, Rs_DEC=1, Rt_DEC=10.
- Load RegDst_DEC=10 with MemRead_DEC=1, then assert IFID_Write=0 and stall_IDEX=1 for 1 cycle:
  - ID/EX bubbles;
  - RegDst_MEM=10, MemRead_MEM=1;
  - IF/ID holds the same Rs/Rt;
  - StallCycles=1.
- stall_IDEX=1, stall_EXMEM=1, stall_MEMWB=0 with ID/EX={7,1,1}:
  - ID/EX holds {7,1,1};
  - EX/MEM becomes 0;
  - WB receives the prior EX/MEM.
- All three stalls=1 -> MEM/WB=0, EX/MEM and ID/EX hold. Release -> the stages advance with no lost entry.
- IF_Flush=1 together with IFID_Write=0 -> IF/ID becomes 0 (Op=0, Rs_DEC=0, Rt_DEC=0); StallCycles unchanged.
- STALL_LIMIT=4: stall_IDEX=1 for 3 cycles then 0 -> Deadlock=0. Then 4 consecutive cycles -> Deadlock=1 and stays 1 after release. Reset -> 0.
